apb_light_scheduler: RTL
========================

Name: apb_light_scheduler

Overview:
- Sequences all APB traffic to the svetofor traffic-light slave on its APB bus.
- Turns a forced-switch request pulse and a periodic poll timer into APB write and read transfers.
- Write target: control register. Read source: current-state register.
- Presents the latest light state, a switch counter and a timeout error to the rest of the design.

Parameters:
- CONTROL_REG_ADDR, 32'h0: APB address of the control register.
- CURRENT_STATE_ADDR, 32'h4: APB address of the current-state register.
- CTRL_SWITCH_DATA, 32'h1: PWDATA value written to force a switch.
- POLL_PERIOD, 16: cycles between automatic state reads; must be ≥2.
- TIMEOUT, 8: maximum ACCESS cycles without PREADY before abort; must be ≥1.
- STATE_W, 2: width of the captured light state.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous reset, active-high.
- req_switch  in  1  force-switch request, sampled each cycle.
- poll_en  in  1  enables the periodic poll timer.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction: 1 = write.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- light_state  out  STATE_W  last state read, taken from PRDATA[STATE_W-1:0].
- state_valid  out  1  one-cycle pulse when light_state updates.
- busy  out  1  high while FSM is not IDLE.
- switch_cnt  out  16  completed switch writes; wraps 16'hFFFF→0.
- err_timeout  out  1  sticky; set on any aborted transfer.

Behaviour:
- Reset (PRESET=1 at an edge):
  - All outputs 0; FSM in IDLE.
  - pend_switch = 0 and pend_poll = 0.
  - Poll timer reloads to POLL_PERIOD-1.
  - Reset mid-transfer drops PSEL/PENABLE on the next edge; no completion side effects occur.
- Pending flags:
  - pend_switch is set when req_switch=1 at an edge.
  - pend_poll is set when the poll timer expires, and on every completed switch write.
  - Repeated requests while a flag is already set coalesce into one transfer.
  - A flag clears on the edge its transfer enters SETUP, so a request arriving during that transfer is kept.
- Poll timer:
  - When poll_en=1, decrements each cycle.
  - At 0 it sets pend_poll and reloads to POLL_PERIOD-1.
  - When poll_en=0, it holds at POLL_PERIOD-1.
- FSM IDLE→SETUP:
  - Taken when any pending flag is set; pend_switch has priority over pend_poll.
  - Operation latched: WRITE_CTRL (PWRITE=1, PADDR=CONTROL_REG_ADDR, PWDATA=CTRL_SWITCH_DATA) or READ_STATE (PWRITE=0, PADDR=CURRENT_STATE_ADDR, PWDATA=0).
  - A req_switch sampled at edge k gives PSEL=1 after edge k+1.
- SETUP:
  - PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA are stable from SETUP through ACCESS.
  - Waits for PREADY; a timeout counter increments each ACCESS cycle.
- Completion (PREADY=1 in ACCESS):
  - WRITE_CTRL: switch_cnt+1 and pend_poll set.
  - READ_STATE: light_state <= PRDATA[STATE_W-1:0], state_valid=1 for one cycle.
  - FSM returns to IDLE; PSEL and PENABLE fall.
- Timeout:
  - If the timeout counter reaches TIMEOUT without PREADY: abort, err_timeout=1, back to IDLE.
  - No retry, no counter update, light_state unchanged.
  - err_timeout clears only on reset.
- Bus idle rules:
  - IDLE always lasts ≥1 cycle, so a minimum transfer is 3 cycles and PSEL is low for ≥1 cycle between transfers.
  - In IDLE, PADDR, PWRITE and PWDATA hold their last values; PSEL=PENABLE=0.
- busy = (FSM != IDLE).

Test Plan:
1. Reset: after PRESET=1 for 2 cycles → all outputs 0; no APB activity for 40 cycles with poll_en=0.
2. Forced switch, PREADY tied 1, poll_en=0:
   - Pulse req_switch → SETUP write to 0x0 with PWDATA=1, switch_cnt=1.
   - Then an automatic read of 0x4; with PRDATA=32'h2 → light_state=2, state_valid pulses once.
3. Periodic poll, POLL_PERIOD=16, poll_en=1, PRDATA stepping 0,1,2 → reads of 0x4 start exactly 16 cycles apart; light_state follows 0,1,2.
4. Coalescing and priority:
   - req_switch held high for 5 cycles while the timer expires the same cycle → write first, then exactly one read.
   - The repeated requests produce one further write: the requests during the first write re-set pend_switch.
   - switch_cnt=2.
5. Wait states and timeout:
   - PREADY delayed 3 cycles → transfer completes, PADDR/PWRITE/PWDATA stable throughout.
   - PREADY never asserted with TIMEOUT=8 → abort after 8 ACCESS cycles, err_timeout=1, switch_cnt unchanged.
6. Reset mid-ACCESS → PSEL=PENABLE=0 next cycle, switch_cnt=0, pending requests discarded.

Source files
------------

// File: rtl/apb_light_scheduler.sv
// APB master that sequences forced-switch writes and periodic state polls
// to the traffic-light slave, reporting the captured state and error status.
module apb_light_scheduler #(
    parameter logic [31:0] CONTROL_REG_ADDR   = 32'h0,
    parameter logic [31:0] CURRENT_STATE_ADDR = 32'h4,
    parameter logic [31:0] CTRL_SWITCH_DATA   = 32'h1,
    parameter int          POLL_PERIOD        = 16,
    parameter int          TIMEOUT            = 8,
    parameter int          STATE_W            = 2
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               req_switch,
    input  logic               poll_en,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [31:0]        PADDR,
    output logic [31:0]        PWDATA,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
    output logic [STATE_W-1:0] light_state,
    output logic               state_valid,
    output logic               busy,
    output logic [15:0]        switch_cnt,
    output logic               err_timeout
);

    localparam int TMR_W = $clog2(POLL_PERIOD);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e              state_q, state_d;
    logic                pend_switch_q, pend_switch_d;
    logic                pend_poll_q, pend_poll_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [TO_W-1:0]     tmo_q, tmo_d;
    logic                pwrite_q, pwrite_d;
    logic [31:0]         paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic [STATE_W-1:0]  light_q, light_d;
    logic                valid_q, valid_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d;

    logic start, sel_write, done, abort, tmr_expire;
    logic unused_prdata;

    // Upper PRDATA bits carry nothing we need.
    assign unused_prdata = ^PRDATA;

    assign start      = (state_q == IDLE) && (pend_switch_q || pend_poll_q);
    assign sel_write  = pend_switch_q;
    assign done       = (state_q == ACCESS) && PREADY;
    assign abort      = (state_q == ACCESS) && !PREADY && (tmo_q == TO_LAST);
    assign tmr_expire = poll_en && (tmr_q == '0);

    always_ff @(posedge PCLK) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        PSEL    = (state_q != IDLE);
        PENABLE = (state_q == ACCESS);
        busy    = (state_q != IDLE);
    end

    // Clearing a flag as its transfer launches takes precedence over a same-edge
    // request; requests landing later in the transfer are retained.
    always_comb begin
        pend_switch_d = pend_switch_q;
        pend_poll_d   = pend_poll_q;
        if (start && sel_write)   pend_switch_d = 1'b0;
        else if (req_switch)      pend_switch_d = 1'b1;
        if (start && !sel_write)                  pend_poll_d = 1'b0;
        else if (tmr_expire || (done && pwrite_q)) pend_poll_d = 1'b1;

        tmr_d = tmr_q - TMR_W'(1);
        if (!poll_en || tmr_q == '0) tmr_d = TMR_RELOAD;

        tmo_d = (state_q == ACCESS) ? tmo_q + TO_W'(1) : '0;

        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        if (start) begin
            pwrite_d = sel_write;
            paddr_d  = sel_write ? CONTROL_REG_ADDR : CURRENT_STATE_ADDR;
            pwdata_d = sel_write ? CTRL_SWITCH_DATA : 32'h0;
        end

        light_d = light_q;
        valid_d = done && !pwrite_q;
        if (done && !pwrite_q) light_d = PRDATA[STATE_W-1:0];
        cnt_d = (done && pwrite_q) ? cnt_q + 16'd1 : cnt_q;
        err_d = err_q | abort;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pend_switch_q <= 1'b0;
            pend_poll_q   <= 1'b0;
            tmr_q         <= TMR_RELOAD;
            tmo_q         <= '0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            light_q       <= '0;
            valid_q       <= 1'b0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            pend_switch_q <= pend_switch_d;
            pend_poll_q   <= pend_poll_d;
            tmr_q         <= tmr_d;
            tmo_q         <= tmo_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            light_q       <= light_d;
            valid_q       <= valid_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
        end
    end

    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign light_state = light_q;
    assign state_valid = valid_q;
    assign switch_cnt  = cnt_q;
    assign err_timeout = err_q;

endmodule
